// File: rtl/rv32i_fetch_exec.sv
// Single-cycle RV32I slice: PC register, decoder and ALU/result mux.
// Latency: all outputs combinational except i_addr (registered PC); no backpressure.
// Illegal opcodes (and branch funct3 2/3, JALR funct3!=0) retire as a no-op and advance PC by 4.
module rv32i_fetch_exec #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [31:0] i_addr,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic [4:0]  rd_addr,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  xfer_size,
    output logic [31:0] ex_result,
    output logic [31:0] store_data,
    output logic        illegal
);

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] op_a, op_b, pc_plus4, target;
    logic        taken, br_eq, br_lt, br_ltu;
    alu_op_t     alu_op;

    assign opcode     = instruction[6:0];
    assign funct3     = instruction[14:12];
    assign rs1_addr   = instruction[19:15];
    assign rs2_addr   = instruction[24:20];
    assign rd_addr    = instruction[11:7];
    assign store_data = rs2_data;
    assign pc_plus4   = i_addr + 32'd4;

    assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u = {instruction[31:12], 12'b0};
    assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};

    assign br_eq  = (rs1_data == rs2_data);
    assign br_lt  = ($signed(rs1_data) < $signed(rs2_data));
    assign br_ltu = (rs1_data < rs2_data);

    // Decode: choose ALU operands/op, write-back and memory controls, and the PC redirect.
    always_comb begin
        op_a       = 32'd0;
        op_b       = 32'd0;
        alu_op     = ALU_ADD;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        xfer_size  = 3'd0;
        illegal    = 1'b0;
        taken      = 1'b0;
        target     = i_addr + imm_b;
        unique case (opcode)
            7'b0110111: begin op_b = imm_u; reg_write = 1'b1; end
            7'b0010111: begin op_a = i_addr; op_b = imm_u; reg_write = 1'b1; end
            7'b1101111: begin
                op_a = i_addr; op_b = 32'd4; reg_write = 1'b1;
                taken = 1'b1; target = i_addr + imm_j;
            end
            7'b1100111: begin
                if (funct3 == 3'd0) begin
                    op_a = i_addr; op_b = 32'd4; reg_write = 1'b1;
                    taken = 1'b1; target = (rs1_data + imm_i) & ~32'd1;
                end else begin
                    illegal = 1'b1;
                end
            end
            7'b1100011: begin
                op_a = rs1_data; op_b = rs2_data; alu_op = ALU_SUB;
                unique case (funct3)
                    3'd0:    taken = br_eq;
                    3'd1:    taken = !br_eq;
                    3'd4:    taken = br_lt;
                    3'd5:    taken = !br_lt;
                    3'd6:    taken = br_ltu;
                    3'd7:    taken = !br_ltu;
                    default: begin illegal = 1'b1; op_a = 32'd0; op_b = 32'd0; alu_op = ALU_ADD; end
                endcase
            end
            7'b0000011: begin
                op_a = rs1_data; op_b = imm_i; xfer_size = funct3;
                mem_read = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1;
            end
            7'b0100011: begin
                op_a = rs1_data; op_b = imm_s; xfer_size = funct3; mem_write = 1'b1;
            end
            7'b0010011, 7'b0110011: begin
                op_a      = rs1_data;
                op_b      = opcode[5] ? rs2_data : imm_i;
                reg_write = 1'b1;
                unique case (funct3)
                    3'd0:    alu_op = (opcode[5] && instruction[30]) ? ALU_SUB : ALU_ADD;
                    3'd1:    alu_op = ALU_SLL;
                    3'd2:    alu_op = ALU_SLT;
                    3'd3:    alu_op = ALU_SLTU;
                    3'd4:    alu_op = ALU_XOR;
                    3'd5:    alu_op = instruction[30] ? ALU_SRA : ALU_SRL;
                    3'd6:    alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        ex_result = 32'd0;
        unique case (alu_op)
            ALU_ADD:  ex_result = op_a + op_b;
            ALU_SUB:  ex_result = op_a - op_b;
            ALU_SLL:  ex_result = op_a << op_b[4:0];
            ALU_SLT:  ex_result = {31'd0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: ex_result = {31'd0, op_a < op_b};
            ALU_XOR:  ex_result = op_a ^ op_b;
            ALU_SRL:  ex_result = op_a >> op_b[4:0];
            ALU_SRA:  ex_result = $signed(op_a) >>> op_b[4:0];
            ALU_OR:   ex_result = op_a | op_b;
            default:  ex_result = op_a & op_b;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) i_addr <= RESET_PC;
        else        i_addr <= taken ? target : pc_plus4;
    end

endmodule

// File: tb/tb_rv32i_fetch_exec.sv
// Bench for rv32i_fetch_exec: directed literal checks plus random instructions vs. a mnemonic-level model.
module tb_rv32i_fetch_exec;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction, rs1_data, rs2_data;
    logic [31:0] i_addr, ex_result, store_data;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        reg_write, mem_to_reg, mem_read, mem_write, illegal;
    logic [2:0]  xfer_size;

    int checks = 0;
    int errors = 0;
    logic        check_en = 1'b0;
    logic [31:0] pc_model = 32'd0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    rv32i_fetch_exec #(.RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .instruction(instruction),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .i_addr(i_addr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_read(mem_read),
        .mem_write(mem_write), .xfer_size(xfer_size), .ex_result(ex_result),
        .store_data(store_data), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] ex;
        logic [31:0] next;
        logic        rw, m2r, mr, mw, ill;
        logic [2:0]  sz;
    } exp_t;

    // Architectural meaning of one instruction, written per mnemonic.
    function automatic exp_t model(input logic [31:0] i, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] pc);
        exp_t e;
        logic [31:0] ii, is, ib, iu, ij, opb;
        logic [4:0]  sh;
        ii = {{20{i[31]}}, i[31:20]};
        is = {{20{i[31]}}, i[31:25], i[11:7]};
        ib = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        iu = {i[31:12], 12'b0};
        ij = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        e = '0;
        e.next = pc + 32'd4;
        case (i[6:0])
            7'h37: begin e.ex = iu; e.rw = 1; end
            7'h17: begin e.ex = pc + iu; e.rw = 1; end
            7'h6F: begin e.ex = pc + 4; e.next = pc + ij; e.rw = 1; end
            7'h67: if (i[14:12] == 0) begin
                       e.ex = pc + 4; e.next = (a + ii) & 32'hFFFF_FFFE; e.rw = 1;
                   end else e.ill = 1;
            7'h63: begin
                logic t;
                t = 0;
                case (i[14:12])
                    0: t = (a == b);
                    1: t = (a != b);
                    4: t = ($signed(a) < $signed(b));
                    5: t = ($signed(a) >= $signed(b));
                    6: t = (a < b);
                    7: t = (a >= b);
                    default: e.ill = 1;
                endcase
                if (!e.ill) begin
                    e.ex = a - b;
                    if (t) e.next = pc + ib;
                end
            end
            7'h03: begin e.ex = a + ii; e.mr = 1; e.m2r = 1; e.rw = 1; e.sz = i[14:12]; end
            7'h23: begin e.ex = a + is; e.mw = 1; e.sz = i[14:12]; end
            7'h13, 7'h33: begin
                opb = (i[6:0] == 7'h33) ? b : ii;
                sh  = opb[4:0];
                e.rw = 1;
                case (i[14:12])
                    0: e.ex = (i[6:0] == 7'h33 && i[30]) ? a - opb : a + opb;
                    1: e.ex = a << sh;
                    2: e.ex = ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0;
                    3: e.ex = (a < opb) ? 32'd1 : 32'd0;
                    4: e.ex = a ^ opb;
                    5: e.ex = i[30] ? 32'($signed(a) >>> sh) : a >> sh;
                    6: e.ex = a | opb;
                    7: e.ex = a & opb;
                endcase
            end
            default: e.ill = 1;
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model; also advances the model PC.
    always @(negedge clk) begin
        if (check_en) begin
            exp_t e;
            if (!reset) pc_model = 32'd0;
            e = model(instruction, rs1_data, rs2_data, pc_model);
            chk("i_addr", i_addr, pc_model);
            chk("rs1_addr", 32'(rs1_addr), 32'(instruction[19:15]));
            chk("rs2_addr", 32'(rs2_addr), 32'(instruction[24:20]));
            chk("rd_addr", 32'(rd_addr), 32'(instruction[11:7]));
            chk("ex_result", ex_result, e.ex);
            chk("reg_write", 32'(reg_write), 32'(e.rw));
            chk("mem_to_reg", 32'(mem_to_reg), 32'(e.m2r));
            chk("mem_read", 32'(mem_read), 32'(e.mr));
            chk("mem_write", 32'(mem_write), 32'(e.mw));
            chk("xfer_size", 32'(xfer_size), 32'(e.sz));
            chk("store_data", store_data, rs2_data);
            chk("illegal", 32'(illegal), 32'(e.ill));
            if (reset) pc_model = e.next;
        end
    end

    task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        instruction = ins;
        rs1_data    = a;
        rs2_data    = b;
    endtask

    task automatic edge_pc(input logic [31:0] exp);
        @(posedge clk);
        #1;
        chk("next_pc", i_addr, exp);
    endtask

    function automatic logic [31:0] gen();
        logic [31:0] r;
        logic [2:0]  f3;
        logic [2:0]  ld_f3 [5];
        logic [6:0]  bad_op [5];
        ld_f3  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        bad_op = '{7'h7F, 7'h00, 7'h0F, 7'h73, 7'h2F};
        r  = $urandom;
        f3 = r[14:12];
        case ($urandom_range(0, 9))
            0: r[6:0] = 7'h37;
            1: r[6:0] = 7'h17;
            2: r[6:0] = 7'h6F;
            3: begin r[6:0] = 7'h67; r[14:12] = 3'd0; end
            4: r[6:0] = 7'h63;
            5: begin r[6:0] = 7'h03; r[14:12] = ld_f3[$urandom_range(0, 4)]; end
            6: begin r[6:0] = 7'h23; r[14:12] = 3'($urandom_range(0, 2)); end
            7: begin
                r[6:0] = 7'h13;
                if (f3 == 3'd1) r[31:25] = 7'd0;
                if (f3 == 3'd5) r[31:25] = {1'b0, r[30], 5'd0};
            end
            8: begin
                r[6:0] = 7'h33;
                r[31:25] = {1'b0, (f3 == 3'd0 || f3 == 3'd5) ? r[30] : 1'b0, 5'd0};
            end
            default: r[6:0] = bad_op[$urandom_range(0, 4)];
        endcase
        return r;
    endfunction

    initial begin
        exp_t m;
        // Pin the model against hand-computed values.
        m = model(32'h0050_0093, 0, 0, 0);           chk("model_addi", m.ex, 32'd5);
        m = model(32'h0020_8463, 3, 3, 32'h10);      chk("model_beq", m.next, 32'h18);
        m = model(32'h0100_00EF, 0, 0, 32'h20);      chk("model_jal", m.next, 32'h30);
        m = model(32'h4040_D193, 32'h8000_0000, 0, 0); chk("model_srai", m.ex, 32'hF800_0000);

        reset = 1'b0;
        drive(NOP, 0, 0);
        #2;
        check_en = 1'b1;
        chk("reset_pc", i_addr, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        chk("release_pc", i_addr, 32'd0);

        drive(32'h0050_0093, 0, 0); #2;
        chk("addi_ex", ex_result, 32'd5);
        chk("addi_rd", 32'(rd_addr), 32'd1);
        chk("addi_rw", 32'(reg_write), 32'd1);
        chk("addi_mem", {30'd0, mem_read, mem_write}, 32'd0);
        edge_pc(32'h4);
        drive(32'h1234_50B7, 0, 0); #2;
        chk("lui_ex", ex_result, 32'h1234_5000);
        edge_pc(32'h8);
        drive(32'h4020_81B3, 7, 9); #2;
        chk("sub_ex", ex_result, 32'hFFFF_FFFE);
        edge_pc(32'hC);
        drive(32'h0020_A1B3, 7, 9); #2;
        chk("slt_ex", ex_result, 32'd1);
        edge_pc(32'h10);
        drive(32'h0020_8463, 3, 4); #2;
        chk("beq_nt_rw", 32'(reg_write), 32'd0);
        edge_pc(32'h14);
        drive(32'h0020_B1B3, 32'hFFFF_FFFF, 1); #2;
        chk("sltu_ex", ex_result, 32'd0);
        edge_pc(32'h18);
        drive(32'h4040_D193, 32'h8000_0000, 0); #2;
        chk("sra_ex", ex_result, 32'hF800_0000);
        edge_pc(32'h1C);
        drive(NOP, 0, 0);
        edge_pc(32'h20);
        drive(32'h0100_00EF, 0, 0); #2;
        chk("jal_ex", ex_result, 32'h24);
        chk("jal_rw", 32'(reg_write), 32'd1);
        edge_pc(32'h30);
        drive(32'h0000_80E7, 32'h101, 0); #2;
        chk("jalr_ex", ex_result, 32'h34);
        edge_pc(32'h100);
        drive(32'h0081_2283, 32'h100, 0); #2;
        chk("lw_ex", ex_result, 32'h108);
        chk("lw_ctl", {29'd0, mem_read, mem_to_reg, reg_write}, 32'h7);
        chk("lw_size", 32'(xfer_size), 32'd2);
        edge_pc(32'h104);
        drive(32'h0051_2623, 32'h100, 32'hDEAD_BEEF); #2;
        chk("sw_ex", ex_result, 32'h10C);
        chk("sw_ctl", {30'd0, mem_write, reg_write}, 32'h2);
        chk("sw_data", store_data, 32'hDEAD_BEEF);
        edge_pc(32'h108);
        drive(32'h0000_007F, 5, 6); #2;
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_ctl", {29'd0, reg_write, mem_read, mem_write}, 32'd0);
        chk("ill_ex", ex_result, 32'd0);
        edge_pc(32'h10C);

        // Reset mid-cycle with a taken jump pending.
        drive(32'h0100_00EF, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_pc", i_addr, 32'd0);
        edge_pc(32'h0);
        reset = 1'b1;
        drive(NOP, 0, 0);
        edge_pc(32'h4);
        edge_pc(32'h8);
        edge_pc(32'hC);
        edge_pc(32'h10);
        drive(32'h0020_8463, 3, 3); #2;
        chk("beq_t_rw", 32'(reg_write), 32'd0);
        edge_pc(32'h18);

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a, b;
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 8));
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            drive(gen(), a, b);
            @(posedge clk);
            #1;
        end

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
